// File: rtl/conv_result_calc.sv
// Multi-slope converter result calculator: shift-add weighted sum per conversion, averaged over 2^AVG_LOG2 samples.
// Optional macro CONV_SAT_OUT_EN clamps out_data to the signed 32-bit range and flags overrun on clamp.
module conv_result_calc #(
  parameter int AVG_LOG2 = 2,
  parameter int OUT_W    = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_stb,
  input  logic [31:0]      pwm_pa,
  input  logic [31:0]      pwm_na,
  input  logic [11:0]      rundown,
  input  logic [7:0]       n64,
  input  logic [7:0]       p8,
  input  logic [7:0]       n1,
  input  logic [2:0]       err_code,
  input  logic             clr,
  output logic             busy,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       err_cnt,
  output logic             overrun
);

  localparam int ACC_W = OUT_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);
`ifdef CONV_SAT_OUT_EN
  localparam logic signed [OUT_W-1:0] SAT_MAX = OUT_W'(64'sd2147483647);
  localparam logic signed [OUT_W-1:0] SAT_MIN = OUT_W'(-64'sd2147483648);
`endif

  typedef enum logic [1:0] {IDLE, CALC, ACCUM, OUT} state_e;

  state_e                   state_q, state_d;
  logic [2:0]               idx_q, idx_d;
  logic [31:0]              pa_q, pa_d, na_q, na_d;
  logic [11:0]              rd_q, rd_d;
  logic [7:0]               n64_q, n64_d, p8_q, p8_d, n1_q, n1_d;
  logic signed [OUT_W-1:0]  sample_q, sample_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic [OUT_W-1:0]         out_data_q, out_data_d;
  logic                     out_valid_q, out_valid_d;
  logic [7:0]               err_cnt_q, err_cnt_d;
  logic                     overrun_q, overrun_d;

  logic signed [32:0]       diff;
  logic [OUT_W-1:0]         term;
  logic signed [ACC_W-1:0]  acc_shr;
  logic signed [OUT_W-1:0]  avg;
  logic signed [OUT_W-1:0]  load_val;
  logic                     clamp;

  // One weighted term per CALC cycle; subtracted terms are negated here so the adder only adds.
  always_comb begin
    diff = $signed({1'b0, pa_q}) - $signed({1'b0, na_q});
    case (idx_q)
      3'd0:    term = OUT_W'(diff) << 9;
      3'd1:    term = -(OUT_W'(rd_q) << 9);
      3'd2:    term = OUT_W'(n64_q) << 6;
      3'd3:    term = -(OUT_W'(p8_q) << 3);
      3'd4:    term = OUT_W'(n1_q);
      default: term = '0;
    endcase
  end

  always_comb begin
    acc_shr = acc_q >>> AVG_LOG2;
    avg     = OUT_W'(acc_shr);
`ifdef CONV_SAT_OUT_EN
    load_val = avg;
    clamp    = 1'b0;
    if (avg > SAT_MAX) begin
      load_val = SAT_MAX;
      clamp    = 1'b1;
    end else if (avg < SAT_MIN) begin
      load_val = SAT_MIN;
      clamp    = 1'b1;
    end
`else
    load_val = avg;
    clamp    = 1'b0;
`endif
  end

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    pa_d        = pa_q;
    na_d        = na_q;
    rd_d        = rd_q;
    n64_d       = n64_q;
    p8_d        = p8_q;
    n1_d        = n1_q;
    sample_d    = sample_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_cnt_d   = err_cnt_q;
    overrun_d   = overrun_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (clr) begin
      acc_d     = '0;
      cnt_d     = '0;
      err_cnt_d = '0;
      overrun_d = 1'b0;
      busy_d    = 1'b0;
      state_d   = IDLE;
    end else begin
      // A strobe arriving mid-computation is lost, never queued.
      if (sample_stb && state_q != IDLE) overrun_d = 1'b1;
      case (state_q)
        IDLE: begin
          if (sample_stb) begin
            if (err_code != 3'd0) begin
              if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
            end else begin
              pa_d     = pwm_pa;
              na_d     = pwm_na;
              rd_d     = rundown;
              n64_d    = n64;
              p8_d     = p8;
              n1_d     = n1;
              sample_d = '0;
              idx_d    = 3'd0;
              busy_d   = 1'b1;
              state_d  = CALC;
            end
          end
        end
        CALC: begin
          sample_d = sample_q + term;
          idx_d    = idx_q + 3'd1;
          if (idx_q == 3'd5) state_d = ACCUM;
        end
        ACCUM: begin
          acc_d = acc_q + ACC_W'(sample_q);
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = OUT;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
        OUT: begin
          if (!out_valid_q || out_ready) begin
            out_data_d  = load_val;
            out_valid_d = 1'b1;
            if (clamp) overrun_d = 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: non-blocking assignments only, so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      pa_q        <= '0;
      na_q        <= '0;
      rd_q        <= '0;
      n64_q       <= '0;
      p8_q        <= '0;
      n1_q        <= '0;
      sample_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pa_q        <= pa_d;
      na_q        <= na_d;
      rd_q        <= rd_d;
      n64_q       <= n64_d;
      p8_q        <= p8_d;
      n1_q        <= n1_d;
      sample_q    <= sample_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_cnt_q   <= err_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign busy      = busy_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign err_cnt   = err_cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_conv_result_calc.sv
// Bench for conv_result_calc: one instance without averaging and one averaging 4 samples, both fed the
// same snapshots and compared against an arithmetic model of the weighted sum and the floor average.
module tb_conv_result_calc;

  logic        clk = 1'b0;
  logic        rst;
  logic        stb, clr, rdy0, rdy2;
  logic [31:0] pa, na;
  logic [11:0] rd;
  logic [7:0]  n64, p8, n1;
  logic [2:0]  ec;

  logic        busy0, valid0, ovr0_o, busy2, valid2, ovr2_o;
  logic [47:0] data0, data2;
  logic [7:0]  errc0, errc2;

  int checks = 0;
  int errors = 0;

  // Model state
  bit     v0, v2, ovr0, ovr2;
  longint d0, d2, sum2;
  int     n2, errs;

  always #5 clk = ~clk;

  conv_result_calc #(.AVG_LOG2(0), .OUT_W(48)) u0 (
    .clk(clk), .rst(rst), .sample_stb(stb), .pwm_pa(pa), .pwm_na(na), .rundown(rd),
    .n64(n64), .p8(p8), .n1(n1), .err_code(ec), .clr(clr), .busy(busy0),
    .out_data(data0), .out_valid(valid0), .out_ready(rdy0), .err_cnt(errc0), .overrun(ovr0_o));

  conv_result_calc #(.AVG_LOG2(2), .OUT_W(48)) u2 (
    .clk(clk), .rst(rst), .sample_stb(stb), .pwm_pa(pa), .pwm_na(na), .rundown(rd),
    .n64(n64), .p8(p8), .n1(n1), .err_code(ec), .clr(clr), .busy(busy2),
    .out_data(data2), .out_valid(valid2), .out_ready(rdy2), .err_cnt(errc2), .overrun(ovr2_o));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] w48(input longint v);
    logic [63:0] t;
    t = v;
    return {16'b0, t[47:0]};
  endfunction

  function automatic longint calc(input logic [31:0] a_pa, a_na, input logic [11:0] a_rd,
                                  input logic [7:0] a64, a8, a1);
    return 512 * (longint'(a_pa) - longint'(a_na)) - 512 * longint'(a_rd)
           + 64 * longint'(a64) - 8 * longint'(a8) + longint'(a1);
  endfunction

  function automatic longint floor_div(input longint s, input longint k);
    longint q;
    q = s / k;
    if ((s % k) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic bit sat_hit(input longint v);
`ifdef CONV_SAT_OUT_EN
    return (v > 64'sd2147483647) || (v < -64'sd2147483648);
`else
    return (v != v);
`endif
  endfunction

  function automatic longint sat_val(input longint v);
`ifdef CONV_SAT_OUT_EN
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
`endif
    return v;
  endfunction

  task automatic strobe(input logic [31:0] a_pa, a_na, input logic [11:0] a_rd,
                        input logic [7:0] a64, a8, a1, input logic [2:0] a_ec);
    @(negedge clk);
    pa = a_pa; na = a_na; rd = a_rd; n64 = a64; p8 = a8; n1 = a1; ec = a_ec;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_ovr0"}, 64'(ovr0_o), 64'(ovr0));
    check({tag, "_ovr2"}, 64'(ovr2_o), 64'(ovr2));
    check({tag, "_errc0"}, 64'(errc0), 64'(errs));
    check({tag, "_errc2"}, 64'(errc2), 64'(errs));
  endtask

  // Entered half a cycle after the strobe edge E0 plus 'done' further cycles.
  task automatic finish_sample(input string tag, input longint s, input int done);
    longint e;
    repeat (7 - done) @(negedge clk);
    check({tag, "_busy0_mid"}, 64'(busy0), 64'(1));
    check({tag, "_valid0_pre"}, 64'(valid0), 64'(v0));
    @(negedge clk);
    e = sat_val(s);
    if (!v0 || rdy0) begin
      v0 = 1'b1; d0 = e;
      if (sat_hit(s)) ovr0 = 1'b1;
    end else begin
      ovr0 = 1'b1;
    end
    sum2 = sum2 + s;
    n2++;
    if (n2 == 4) begin
      e = floor_div(sum2, 4);
      if (!v2 || rdy2) begin
        v2 = 1'b1; d2 = sat_val(e);
        if (sat_hit(e)) ovr2 = 1'b1;
      end else begin
        ovr2 = 1'b1;
      end
      sum2 = 0; n2 = 0;
    end
    check({tag, "_valid0"}, 64'(valid0), 64'(v0));
    check({tag, "_data0"}, {16'b0, data0}, w48(d0));
    check({tag, "_valid2"}, 64'(valid2), 64'(v2));
    check({tag, "_data2"}, {16'b0, data2}, w48(d2));
    check({tag, "_busy0"}, 64'(busy0), 64'(0));
    check({tag, "_busy2"}, 64'(busy2), 64'(0));
    @(negedge clk);
    if (rdy0) v0 = 1'b0;
    if (rdy2) v2 = 1'b0;
    check({tag, "_valid0_post"}, 64'(valid0), 64'(v0));
    check({tag, "_valid2_post"}, 64'(valid2), 64'(v2));
    check_status(tag);
  endtask

  task automatic good(input string tag, input logic [31:0] a_pa, a_na, input logic [11:0] a_rd,
                      input logic [7:0] a64, a8, a1);
    strobe(a_pa, a_na, a_rd, a64, a8, a1, 3'd0);
    finish_sample(tag, calc(a_pa, a_na, a_rd, a64, a8, a1), 0);
  endtask

  task automatic err_sample(input string tag, input logic [2:0] a_ec);
    strobe($urandom, $urandom, 12'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), a_ec);
    @(negedge clk);
    if (errs < 255) errs++;
    check({tag, "_busy0"}, 64'(busy0), 64'(0));
    check_status(tag);
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ovr0 = 1'b0; ovr2 = 1'b0; errs = 0; sum2 = 0; n2 = 0;
  endtask

  initial begin
    rst = 1'b0; stb = 1'b0; clr = 1'b0; rdy0 = 1'b1; rdy2 = 1'b1;
    pa = '0; na = '0; rd = '0; n64 = '0; p8 = '0; n1 = '0; ec = '0;
    v0 = 0; v2 = 0; ovr0 = 0; ovr2 = 0; d0 = 0; d2 = 0; sum2 = 0; n2 = 0; errs = 0;
    repeat (3) @(negedge clk);
    check("rst_valid0", 64'(valid0), 64'(0));
    check("rst_data0", {16'b0, data0}, 64'(0));
    check("rst_busy0", 64'(busy0), 64'(0));
    check("rst_data2", {16'b0, data2}, 64'(0));
    check_status("rst");
    rst = 1'b1;
    @(negedge clk);

    good("basic", 32'd1000, 32'd400, 12'd10, 8'd3, 8'd5, 8'd7);
    check("basic_const", {16'b0, data0}, w48(64'sd302239));
    good("neg", 32'd0, 32'd1, 12'd0, 8'd0, 8'd0, 8'd0);
    check("neg_const", {16'b0, data0}, w48(-64'sd512));

    do_clr();
    good("avg_a", 0, 0, 0, 0, 0, 8'd100);
    good("avg_b", 0, 0, 0, 0, 0, 8'd101);
    good("avg_c", 0, 0, 0, 0, 0, 8'd102);
    good("avg_d", 0, 0, 0, 0, 0, 8'd104);
    check("avg_const", {16'b0, data2}, w48(64'sd101));
    good("avgn_a", 0, 0, 12'd1, 0, 0, 0);
    good("avgn_b", 0, 0, 0, 0, 0, 0);
    good("avgn_c", 0, 0, 0, 0, 0, 0);
    good("avgn_d", 0, 0, 0, 0, 0, 0);
    check("avgn_const", {16'b0, data2}, w48(-64'sd128));

    err_sample("errdrop", 3'd3);
    check("errdrop_const", 64'(errc0), 64'(1));

    // Second strobe lands at E0+2 while the first sample is in flight.
    strobe(32'd5000, 32'd1234, 12'd77, 8'd9, 8'd8, 8'd6, 3'd0);
    @(negedge clk);
    pa = 32'd999999; rd = 12'd4000; stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    ovr0 = 1'b1; ovr2 = 1'b1;
    finish_sample("busystb", calc(32'd5000, 32'd1234, 12'd77, 8'd9, 8'd8, 8'd6), 2);

    do_clr();
    check_status("clr");

    // clr during CALC aborts the conversion without producing output.
    strobe(32'd42, 32'd0, 0, 0, 0, 0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    ovr0 = 0; ovr2 = 0; errs = 0; sum2 = 0; n2 = 0;
    check("abort_busy0", 64'(busy0), 64'(0));
    check("abort_busy2", 64'(busy2), 64'(0));
    repeat (6) @(negedge clk);
    check("abort_valid0", 64'(valid0), 64'(0));

    // clr and a strobe on the same clock: the strobe is ignored.
    @(negedge clk);
    clr = 1'b1; stb = 1'b1; pa = 32'd77;
    @(negedge clk);
    clr = 1'b0; stb = 1'b0;
    check("clrstb_busy0", 64'(busy0), 64'(0));
    repeat (9) @(negedge clk);
    check("clrstb_valid0", 64'(valid0), 64'(0));
    check_status("clrstb");

    rdy0 = 1'b0;
    good("bp_a", 32'd300, 32'd100, 12'd5, 8'd1, 8'd2, 8'd3);
    repeat (10) @(negedge clk);
    good("bp_b", 32'd7, 32'd900, 12'd0, 0, 0, 0);
    @(negedge clk);
    rdy0 = 1'b1;
    @(negedge clk);
    rdy0 = 1'b0;
    v0 = 1'b0;
    check("bp_fall", 64'(valid0), 64'(0));
    rdy0 = 1'b1;

    do_clr();
    good("sat", 32'hFFFF_FFFF, 32'd0, 0, 0, 0, 0);
`ifdef CONV_SAT_OUT_EN
    check("sat_const", {16'b0, data0}, w48(64'sd2147483647));
`else
    check("sat_const", {16'b0, data0}, w48(64'sd2199023255040));
`endif

    do_clr();
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0)
        err_sample("rnd_err", 3'($urandom_range(1, 7)));
      else
        good("rnd", $urandom, $urandom, 12'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
